// File: rtl/wire_test_sequencer.sv
// Self-test sequencer for the A -> (B, C) wire datapath: steps A through a
// fixed pattern, samples B and C at the end of each hold and reports results.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_IDLE  | after reset; a_out parked at IDLE_A, waiting for start
//   ST_DRIVE | pattern running; busy high, sampling on last hold cycle
//   ST_DONE  | run finished; results held until next start or reset
module wire_test_sequencer #(
    parameter int          HOLD_CYCLES = 20,
    parameter int          NUM_STEPS   = 4,
    parameter logic [31:0] PATTERN     = 32'h0000_000A,
    parameter logic        IDLE_A      = 1'b0,
    parameter logic        EXP_B_INV   = 1'b0,
    parameter logic        EXP_C_INV   = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       b_in,
    input  logic       c_in,
    output logic       a_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [5:0] err_count,
    output logic       first_fail_valid,
    output logic [4:0] first_fail_step
);

    localparam int            HW        = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [4:0]    LAST_STEP = 5'(NUM_STEPS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_DONE} state_t;

    state_t        state;
    logic [4:0]    step;
    logic [HW-1:0] hold;

    logic       exp_a;
    logic       step_fail;
    logic [5:0] err_next;
    logic [4:0] step_nxt;

    // A step fails once even when both B and C mismatch; the count saturates.
    always_comb begin
        exp_a     = PATTERN[step];
        step_fail = (b_in != (exp_a ^ EXP_B_INV)) || (c_in != (exp_a ^ EXP_C_INV));
        err_next  = (step_fail && (err_count != 6'd63)) ? err_count + 6'd1 : err_count;
        step_nxt  = step + 5'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            step             <= '0;
            hold             <= '0;
            a_out            <= IDLE_A;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_step  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state            <= ST_DRIVE;
                        step             <= '0;
                        hold             <= HOLD_LOAD;
                        a_out            <= PATTERN[0];
                        busy             <= 1'b1;
                        pass             <= 1'b0;
                        err_count        <= '0;
                        first_fail_valid <= 1'b0;
                        first_fail_step  <= '0;
                    end
                end
                ST_DRIVE: begin
                    if (hold == '0) begin
                        err_count <= err_next;
                        if (step_fail && !first_fail_valid) begin
                            first_fail_valid <= 1'b1;
                            first_fail_step  <= step;
                        end
                        if (step == LAST_STEP) begin
                            state <= ST_DONE;
                            a_out <= IDLE_A;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_next == 6'd0);
                        end else begin
                            step  <= step_nxt;
                            hold  <= HOLD_LOAD;
                            a_out <= PATTERN[step_nxt];
                        end
                    end else begin
                        hold <= hold - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wire_test_sequencer.sv
// Scoreboard bench: three sequencer builds (default, inverted C, one-cycle hold)
// with loopback / stuck-at datapath models; a monitor checks every done pulse.
module tb_wire_test_sequencer;

    typedef struct {
        int          idx;
        int          hold;
        int          len;
        logic [31:0] pat;
        logic        pass;
        logic [5:0]  err;
        logic        ffv;
        logic [4:0]  ffs;
    } exp_t;

    logic       clk = 1'b0;
    logic [2:0] rst_n = 3'b000;
    logic [2:0] start = 3'b000;
    logic [2:0] b, c, a_out, busy, done, pass, ffv;
    logic [5:0] err [3];
    logic [4:0] ffs [3];
    logic [2:0] bmode = 3'b000;   // 1: B stuck at 0, else B = A
    logic [2:0] cmode = 3'b000;   // 1: C = NOT A, else C = A

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    assign b[0] = bmode[0] ? 1'b0 : a_out[0];
    assign b[1] = bmode[1] ? 1'b0 : a_out[1];
    assign b[2] = bmode[2] ? 1'b0 : a_out[2];
    assign c[0] = cmode[0] ? ~a_out[0] : a_out[0];
    assign c[1] = cmode[1] ? ~a_out[1] : a_out[1];
    assign c[2] = cmode[2] ? ~a_out[2] : a_out[2];

    wire_test_sequencer u_def (
        .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .b_in(b[0]), .c_in(c[0]),
        .a_out(a_out[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_count(err[0]), .first_fail_valid(ffv[0]), .first_fail_step(ffs[0]));

    wire_test_sequencer #(.EXP_C_INV(1'b1)) u_cinv (
        .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .b_in(b[1]), .c_in(c[1]),
        .a_out(a_out[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_count(err[1]), .first_fail_valid(ffv[1]), .first_fail_step(ffs[1]));

    wire_test_sequencer #(.HOLD_CYCLES(1)) u_h1 (
        .clk(clk), .rst_n(rst_n[2]), .start(start[2]), .b_in(b[2]), .c_in(c[2]),
        .a_out(a_out[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
        .err_count(err[2]), .first_fail_valid(ffv[2]), .first_fail_step(ffs[2]));

    function automatic void chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Monitor: checks a_out while running, busy length and results at each done.
    logic [2:0] prev_busy = 3'b000;
    logic [2:0] prev_done = 3'b000;
    int         cnt [3] = '{0, 0, 0};

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (busy[i]) begin
                int k;
                k = prev_busy[i] ? cnt[i] : 0;
                if (sb.size() > 0 && sb[0].idx == i && k < sb[0].len)
                    chk($sformatf("a_out[%0d] busy cycle %0d", i, k), a_out[i], sb[0].pat[k / sb[0].hold]);
                cnt[i] = k + 1;
            end else begin
                chk($sformatf("a_out idle[%0d]", i), a_out[i], 0);
            end
            if (prev_done[i])
                chk($sformatf("done single pulse[%0d]", i), done[i], 0);
            if (done[i]) begin
                if (sb.size() == 0) begin
                    chk($sformatf("unexpected done[%0d]", i), 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done dut index", i, e.idx);
                    chk($sformatf("busy length[%0d]", i), cnt[i], e.len);
                    chk($sformatf("pass[%0d]", i), pass[i], e.pass);
                    chk($sformatf("err_count[%0d]", i), err[i], e.err);
                    chk($sformatf("first_fail_valid[%0d]", i), ffv[i], e.ffv);
                    chk($sformatf("first_fail_step[%0d]", i), ffs[i], e.ffs);
                end
            end
            prev_busy[i] = busy[i];
            prev_done[i] = done[i];
        end
    end

    task automatic push(int idx, int hold, logic ps, logic [5:0] er, logic fv, logic [4:0] fs);
        exp_t e;
        e.idx = idx; e.hold = hold; e.len = 4 * hold; e.pat = 32'h0000_000A;
        e.pass = ps; e.err = er; e.ffv = fv; e.ffs = fs;
        sb.push_back(e);
    endtask

    task automatic pulse(int i);
        @(posedge clk); #1 start[i] = 1'b1;
        @(posedge clk); #1 start[i] = 1'b0;
    endtask

    task automatic wait_empty(string name, int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk({name, " timeout waiting for done"}, 0, 1);
            sb.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset a_out[%0d]", i), a_out[i], 0);
            chk($sformatf("reset busy[%0d]", i), busy[i], 0);
            chk($sformatf("reset done[%0d]", i), done[i], 0);
            chk($sformatf("reset pass[%0d]", i), pass[i], 0);
            chk($sformatf("reset err[%0d]", i), err[i], 0);
            chk($sformatf("reset ffv[%0d]", i), ffv[i], 0);
            chk($sformatf("reset ffs[%0d]", i), ffs[i], 0);
        end
        @(posedge clk); #1 rst_n = 3'b111;

        // Loopback on default build
        push(0, 20, 1'b1, 6'd0, 1'b0, 5'd0);
        pulse(0);
        wait_empty("loopback", 200);

        // B stuck at 0: steps 1 and 3 fail
        bmode[0] = 1'b1;
        push(0, 20, 1'b0, 6'd2, 1'b1, 5'd1);
        pulse(0);
        wait_empty("b stuck", 200);

        // Restart from a failing DONE clears results; start mid-run ignored
        bmode[0] = 1'b0;
        push(0, 20, 1'b1, 6'd0, 1'b0, 5'd0);
        pulse(0);
        chk("restart clears err", err[0], 0);
        chk("restart clears ffv", ffv[0], 0);
        chk("restart clears pass", pass[0], 0);
        chk("restart busy", busy[0], 1);
        repeat (28) @(posedge clk);
        pulse(0);
        wait_empty("restart ignored", 200);

        // Inverted-C build
        cmode[1] = 1'b1;
        push(1, 20, 1'b1, 6'd0, 1'b0, 5'd0);
        pulse(1);
        wait_empty("c inverted ok", 200);
        cmode[1] = 1'b0;
        push(1, 20, 1'b0, 6'd4, 1'b1, 5'd0);
        pulse(1);
        wait_empty("c not inverted", 200);

        // Reset mid-run at cycle 45 with one failure already recorded
        bmode[0] = 1'b1;
        pulse(0);
        repeat (44) @(posedge clk);
        #1;
        chk("pre-reset err", err[0], 1);
        #2 rst_n[0] = 1'b0;
        #1;
        chk("midrun reset a_out", a_out[0], 0);
        chk("midrun reset busy", busy[0], 0);
        chk("midrun reset err", err[0], 0);
        chk("midrun reset ffv", ffv[0], 0);
        chk("midrun reset done", done[0], 0);
        repeat (2) @(posedge clk);
        #1 rst_n[0] = 1'b1;
        repeat (60) @(posedge clk);
        bmode[0] = 1'b0;
        push(0, 20, 1'b1, 6'd0, 1'b0, 5'd0);
        pulse(0);
        wait_empty("after reset", 200);

        // One-cycle hold build
        push(2, 1, 1'b1, 6'd0, 1'b0, 5'd0);
        pulse(2);
        wait_empty("hold one", 50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
